// File: rtl/cpu_pkg.sv
// Shared SM83 core definitions: register encodings, pair encodings and CHNZ flag bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_F = 3'd6,
        REG_A = 3'd7
    } reg8_e;

    // RR_SP selects AF instead when the pair port's af qualifier is set
    typedef enum logic [1:0] {
        RR_BC = 2'd0,
        RR_DE = 2'd1,
        RR_HL = 2'd2,
        RR_SP = 2'd3
    } reg16_e;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

    // Byte slots backing a pair; pair 3 maps to A:F (only meaningful when AF is selected)
    function automatic logic [2:0] pair_hi(input logic [1:0] sel);
        return (sel == RR_SP) ? REG_A : {sel, 1'b0};
    endfunction

    function automatic logic [2:0] pair_lo(input logic [1:0] sel);
        return (sel == RR_SP) ? REG_F : {sel, 1'b1};
    endfunction

endpackage

// File: rtl/cpu_idu.sv
// 16-bit increment/decrement unit, modulo 2^16, no flags.
module cpu_idu (
    input  logic [15:0] value_i,
    input  logic        dec_i,
    output logic [15:0] result_o
);

    always_comb begin
        result_o = dec_i ? (value_i - 16'd1) : (value_i + 16'd1);
    end

endmodule

// File: rtl/cpu_regfile.sv
// SM83 architectural register file: 8-bit ALU ports, flag nibble, 16-bit pair port with IDU, and PC.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  rd_a_sel,
    input  logic [2:0]  rd_b_sel,
    output logic [7:0]  rd_a,
    output logic [7:0]  rd_b,
    output logic [3:0]  flags,
    input  logic        wr_en,
    input  logic [2:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic        flag_wr_en,
    input  logic [3:0]  flag_in,
    input  logic [1:0]  rr_sel,
    input  logic        rr_af,
    output logic [15:0] rr_out,
    input  logic        rr_wr_en,
    input  logic [15:0] rr_wr_data,
    input  logic        idu_en,
    input  logic        idu_dec,
    output logic [15:0] pc,
    input  logic        pc_inc,
    input  logic        pc_wr_en,
    input  logic [15:0] pc_wr_data
);

    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic [15:0] sp_q, sp_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] idu_result;
    logic [15:0] pair_wdata;
    logic        pair_is_sp;
    logic        pair_wr;

    assign pair_is_sp = (rr_sel == RR_SP) && !rr_af;
    assign pair_wr    = rr_wr_en || idu_en;
    assign pair_wdata = rr_wr_en ? rr_wr_data : idu_result;

    assign rd_a   = regs_q[rd_a_sel];
    assign rd_b   = regs_q[rd_b_sel];
    assign flags  = regs_q[REG_F][7:4];
    assign rr_out = pair_is_sp ? sp_q : {regs_q[pair_hi(rr_sel)], regs_q[pair_lo(rr_sel)]};
    assign pc     = pc_q;

    cpu_idu u_idu (
        .value_i  (rr_out),
        .dec_i    (idu_dec),
        .result_o (idu_result)
    );

    // Writers applied lowest priority first so higher-priority strobes overwrite shared bytes
    always_comb begin
        regs_d = regs_q;
        sp_d   = sp_q;
        if (wr_en) begin
            regs_d[wr_sel] = wr_data;
        end
        if (flag_wr_en) begin
            regs_d[REG_F][7:4] = flag_in;
        end
        if (pair_wr) begin
            if (pair_is_sp) begin
                sp_d = pair_wdata;
            end else begin
                regs_d[pair_hi(rr_sel)] = pair_wdata[15:8];
                regs_d[pair_lo(rr_sel)] = pair_wdata[7:0];
            end
        end
        regs_d[REG_F][3:0] = '0;
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_wr_en) begin
            pc_d = pc_wr_data;
        end else if (pc_inc) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: 8'h00};
            sp_q   <= SP_RESET;
            pc_q   <= PC_RESET;
        end else begin
            regs_q <= regs_d;
            sp_q   <= sp_d;
            pc_q   <= pc_d;
        end
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile: directed scenarios plus randomized traffic against a pair-level model.
module tb_cpu_regfile;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  rd_a_sel = '0;
    logic [2:0]  rd_b_sel = '0;
    logic [7:0]  rd_a, rd_b;
    logic [3:0]  flags;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [7:0]  wr_data = '0;
    logic        flag_wr_en = 1'b0;
    logic [3:0]  flag_in = '0;
    logic [1:0]  rr_sel = '0;
    logic        rr_af = 1'b0;
    logic [15:0] rr_out;
    logic        rr_wr_en = 1'b0;
    logic [15:0] rr_wr_data = '0;
    logic        idu_en = 1'b0;
    logic        idu_dec = 1'b0;
    logic [15:0] pc;
    logic        pc_inc = 1'b0;
    logic        pc_wr_en = 1'b0;
    logic [15:0] pc_wr_data = '0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    cpu_regfile #(.PC_RESET(16'h0000), .SP_RESET(16'hFFFE)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_a(rd_a), .rd_b(rd_b), .flags(flags),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .flag_wr_en(flag_wr_en), .flag_in(flag_in),
        .rr_sel(rr_sel), .rr_af(rr_af), .rr_out(rr_out),
        .rr_wr_en(rr_wr_en), .rr_wr_data(rr_wr_data),
        .idu_en(idu_en), .idu_dec(idu_dec),
        .pc(pc), .pc_inc(pc_inc), .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data)
    );

    // Model holds pairs as words and the flags as a bare nibble
    logic [15:0] m_bc, m_de, m_hl, m_sp, m_pc, m_old;
    logic [7:0]  m_a;
    logic [3:0]  m_f;

    function automatic logic [7:0] m_r8(input logic [2:0] s);
        case (s)
            3'd0:    return m_bc[15:8];
            3'd1:    return m_bc[7:0];
            3'd2:    return m_de[15:8];
            3'd3:    return m_de[7:0];
            3'd4:    return m_hl[15:8];
            3'd5:    return m_hl[7:0];
            3'd6:    return {m_f, 4'h0};
            default: return m_a;
        endcase
    endfunction

    function automatic logic [15:0] m_pair(input logic [1:0] s, input logic af);
        case (s)
            2'd0:    return m_bc;
            2'd1:    return m_de;
            2'd2:    return m_hl;
            default: return af ? {m_a, m_f, 4'h0} : m_sp;
        endcase
    endfunction

    task automatic m_set8(input logic [2:0] s, input logic [7:0] v);
        case (s)
            3'd0:    m_bc[15:8] = v;
            3'd1:    m_bc[7:0]  = v;
            3'd2:    m_de[15:8] = v;
            3'd3:    m_de[7:0]  = v;
            3'd4:    m_hl[15:8] = v;
            3'd5:    m_hl[7:0]  = v;
            3'd6:    m_f        = v[7:4];
            default: m_a        = v;
        endcase
    endtask

    task automatic m_set16(input logic [1:0] s, input logic af, input logic [15:0] v);
        case (s)
            2'd0: m_bc = v;
            2'd1: m_de = v;
            2'd2: m_hl = v;
            default: begin
                if (af) begin
                    m_a = v[15:8];
                    m_f = v[7:4];
                end else begin
                    m_sp = v;
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_bc = '0; m_de = '0; m_hl = '0; m_a = '0; m_f = '0;
            m_sp = 16'hFFFE;
            m_pc = 16'h0000;
        end else begin
            m_old = m_pair(rr_sel, rr_af);
            if (wr_en) m_set8(wr_sel, wr_data);
            if (flag_wr_en) m_f = flag_in;
            if (rr_wr_en) m_set16(rr_sel, rr_af, rr_wr_data);
            else if (idu_en) m_set16(rr_sel, rr_af, idu_dec ? m_old - 16'd1 : m_old + 16'd1);
            if (pc_wr_en) m_pc = pc_wr_data;
            else if (pc_inc) m_pc = m_pc + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("model_rd_a", {8'h00, rd_a}, {8'h00, m_r8(rd_a_sel)});
            chk("model_rd_b", {8'h00, rd_b}, {8'h00, m_r8(rd_b_sel)});
            chk("model_flags", {12'h000, flags}, {12'h000, m_f});
            chk("model_rr_out", rr_out, m_pair(rr_sel, rr_af));
            chk("model_pc", pc, m_pc);
        end
    end

    task automatic idle();
        wr_en = 1'b0; flag_wr_en = 1'b0; rr_wr_en = 1'b0;
        idu_en = 1'b0; pc_inc = 1'b0; pc_wr_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        rd_a_sel   = 3'($urandom);
        rd_b_sel   = 3'($urandom);
        wr_en      = ($urandom_range(0, 2) == 0);
        wr_sel     = 3'($urandom);
        wr_data    = 8'($urandom);
        flag_wr_en = ($urandom_range(0, 2) == 0);
        flag_in    = 4'($urandom);
        rr_sel     = 2'($urandom);
        rr_af      = 1'($urandom);
        rr_wr_en   = ($urandom_range(0, 3) == 0);
        rr_wr_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        idu_en     = ($urandom_range(0, 2) == 0);
        idu_dec    = 1'($urandom);
        pc_inc     = ($urandom_range(0, 1) == 0);
        pc_wr_en   = ($urandom_range(0, 4) == 0);
        pc_wr_data = 16'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_a_sel = 3'(i);
            #1;
            chk({tag, "_r8"}, {8'h00, rd_a}, 16'h0000);
        end
        rr_sel = 2'd3;
        rr_af  = 1'b0;
        #1;
        chk({tag, "_sp"}, rr_out, 16'hFFFE);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_flags"}, {12'h000, flags}, 16'h0000);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset");
        tick();
        tick();
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // F low nibble is hardwired zero
        wr_en = 1'b1; wr_sel = 3'd6; wr_data = 8'hFF;
        tick(); idle(); rd_a_sel = 3'd6; #1;
        chk("f_mask_rd", {8'h00, rd_a}, 16'h00F0);
        chk("f_mask_flags", {12'h000, flags}, 16'h000F);
        flag_wr_en = 1'b1; flag_in = 4'b0101;
        tick(); idle(); #1;
        chk("f_flag_write", {8'h00, rd_a}, 16'h0050);

        // ALU result and flags commit together; same-cycle read sees old A
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h3C;
        flag_wr_en = 1'b1; flag_in = 4'b1000; rd_a_sel = 3'd7; #1;
        chk("a_old_read", {8'h00, rd_a}, 16'h0000);
        tick(); idle(); #1;
        chk("a_writeback", {8'h00, rd_a}, 16'h003C);
        chk("a_flags", {12'h000, flags}, 16'h0008);

        // IDU wrap on HL and SP, plus concurrent 8-bit write to B
        rr_sel = 2'd2; rr_af = 1'b0; rr_wr_en = 1'b1; rr_wr_data = 16'h0000;
        tick(); idle();
        idu_en = 1'b1; idu_dec = 1'b1;
        tick(); idle(); #1;
        chk("hl_dec_wrap", rr_out, 16'hFFFF);
        idu_en = 1'b1; idu_dec = 1'b0; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h5A;
        tick(); idle(); rd_a_sel = 3'd0; #1;
        chk("hl_inc_wrap", rr_out, 16'h0000);
        chk("b_with_idu", {8'h00, rd_a}, 16'h005A);
        rr_sel = 2'd3; rr_wr_en = 1'b1; rr_wr_data = 16'hFFFF;
        tick(); idle();
        idu_en = 1'b1; idu_dec = 1'b0;
        tick(); idle(); #1;
        chk("sp_inc_wrap", rr_out, 16'h0000);

        // Priority: pair write beats IDU and byte write; PC load beats increment
        rr_sel = 2'd0; rr_wr_en = 1'b1; rr_wr_data = 16'h1234;
        idu_en = 1'b1; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'hAA;
        tick(); idle(); #1;
        chk("prio_bc", rr_out, 16'h1234);
        pc_wr_en = 1'b1; pc_wr_data = 16'h0150; pc_inc = 1'b1;
        tick(); idle(); #1;
        chk("prio_pc", pc, 16'h0150);
        pc_wr_en = 1'b1; pc_wr_data = 16'hFFFF;
        tick(); idle();
        pc_inc = 1'b1;
        tick(); idle(); #1;
        chk("pc_wrap", pc, 16'h0000);

        // AF pair write drops F low nibble
        rr_af = 1'b1; rr_sel = 2'd3; rr_wr_en = 1'b1; rr_wr_data = 16'h12FF;
        tick(); idle(); rd_a_sel = 3'd7; rd_b_sel = 3'd6; #1;
        chk("af_a", {8'h00, rd_a}, 16'h0012);
        chk("af_f", {8'h00, rd_b}, 16'h00F0);
        chk("af_pair", rr_out, 16'h12F0);

        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            tick();
        end

        // Asynchronous reset mid-run with strobes active
        randomize_inputs();
        #2 reset_n = 1'b0;
        #1 idle();
        check_reset_values("async_reset");
        tick();
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            randomize_inputs();
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
